// File: rtl/mem_block_mover.sv
// Block copy/fill initiator for a 32-entry single-port memory.
// Walks addresses in ascending order and returns a wrapping checksum of the words written.
module mem_block_mover #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [4:0]       src,
  input  logic [4:0]       dst,
  input  logic [5:0]       len,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [4:0]       mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic             mode_r;
  logic [4:0]       src_r;
  logic [4:0]       dst_r;
  logic [5:0]       len_r;
  logic [5:0]       idx;
  logic [WIDTH-1:0] pattern_r;
  logic [5:0]       len_c;
  logic [5:0]       idx_next;

  assign len_c    = (len > 6'd32) ? 6'd32 : len;
  assign idx_next = idx + 6'd1;

  // Port outputs are registered: each transition loads the values the next state drives.
  // In COPY, mem_wd doubles as the hold register for the word read in RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      mode_r    <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      len_r     <= '0;
      idx       <= '0;
      pattern_r <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r    <= mode;
            src_r     <= src;
            dst_r     <= dst;
            len_r     <= len_c;
            pattern_r <= pattern;
            idx       <= '0;
            checksum  <= '0;
            busy      <= 1'b1;
            if (len_c == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!mode) begin
              state    <= RD;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= src;
            end else begin
              state    <= WR;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= dst;
              mem_wd   <= pattern;
            end
          end
        end

        RD: begin
          state    <= WR;
          mem_we   <= 1'b1;
          mem_addr <= dst_r + idx[4:0];
          mem_wd   <= mem_rd;
        end

        WR: begin
          checksum <= checksum + mem_wd;
          idx      <= idx_next;
          if (idx_next == len_r) begin
            state  <= DONE;
            done   <= 1'b1;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
          end else if (!mode_r) begin
            state    <= RD;
            mem_we   <= 1'b0;
            mem_addr <= src_r + idx_next[4:0];
          end else begin
            mem_addr <= dst_r + idx_next[4:0];
            mem_wd   <= pattern_r;
          end
        end

        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover: directed cases plus random commands
// compared against a word-by-word array model of the copy/fill.
module tb_mem_block_mover;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [4:0]       src;
  logic [4:0]       dst;
  logic [5:0]       len;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] checksum;
  logic             mem_cs;
  logic             mem_we;
  logic [4:0]       mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  logic [WIDTH-1:0] mem [32];
  logic [WIDTH-1:0] ref_mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_block_mover #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // Single-port memory the DUT drives.
  assign mem_rd = mem_cs ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int k = 0; k < 32; k++) if (mem[k] !== ref_mem[k]) d++;
    return d;
  endfunction

  // Issue one command, model it, watch the bus until done, then compare.
  // With again=1 a second start with other arguments is pulsed while busy.
  task automatic run_cmd(input logic m, input logic [4:0] s, input logic [4:0] d,
                         input logic [5:0] l, input logic [31:0] p, input logic again,
                         input string tag);
    int n, exp_done, exp_cs, cs_cnt, done_cnt, done_cyc, after;
    logic [31:0] sum, w;
    logic busy_c1;
    n = (l > 6'd32) ? 32 : int'(l);
    for (int k = 0; k < 32; k++) ref_mem[k] = mem[k];
    sum = 0;
    for (int k = 0; k < n; k++) begin
      w = m ? p : ref_mem[(int'(s) + k) % 32];
      ref_mem[(int'(d) + k) % 32] = w;
      sum += w;
    end
    exp_done = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    exp_cs   = m ? n : 2 * n;

    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = l; pattern = p;
    cs_cnt = 0; done_cnt = 0; done_cyc = 0; after = 0; busy_c1 = 1'b0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (again && n > 0 && cyc == 2) begin
        start = 1'b1; mode = ~m; src = s + 5'd9; dst = d + 5'd13;
        len = 6'd7; pattern = ~p;
      end
      if (cyc == 1) busy_c1 = busy;
      if (mem_cs) cs_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0) after++;
      if (after > 3) break;
    end
    start = 1'b0;
    check({tag, "_busy1"}, 32'(busy_c1), 32'd1);
    check({tag, "_donecyc"}, done_cyc, exp_done);
    check({tag, "_donecnt"}, done_cnt, 1);
    check({tag, "_cscyc"}, cs_cnt, exp_cs);
    check({tag, "_sum"}, checksum, sum);
    check({tag, "_mem"}, mem_diffs(), 0);
    check({tag, "_idle"}, {busy, mem_cs, mem_we}, 0);
  endtask

  initial begin
    logic [4:0] rs, rd;
    logic [31:0] rp;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cs", 32'(mem_cs), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wd", mem_wd, 0);
    check("rst_sum", checksum, 0);
    rst = 1'b0;

    // Copy of four known words
    for (int k = 0; k < 4; k++) mem[4 + k] = k + 1;
    run_cmd(1'b0, 5'd4, 5'd20, 6'd4, 32'h0, 1'b0, "t1");
    check("t1_sum10", checksum, 32'd10);
    check("t1_m23", mem[23], 32'd4);

    // Fill wrapping past address 31
    run_cmd(1'b1, 5'd30, 5'd30, 6'd4, 32'hA5A5_A5A5, 1'b0, "t2");
    check("t2_sumk", checksum, 32'h9696_9694);
    check("t2_m1", mem[1], 32'hA5A5_A5A5);

    // Zero-length commands in both modes
    run_cmd(1'b0, 5'd3, 5'd9, 6'd0, 32'h0, 1'b0, "t3c");
    run_cmd(1'b1, 5'd3, 5'd9, 6'd0, 32'h1234, 1'b0, "t3f");
    check("t3_sum0", checksum, 0);

    // Second start while busy is ignored
    run_cmd(1'b1, 5'd0, 5'd12, 6'd6, 32'hDEAD_BEEF, 1'b1, "t4f");
    run_cmd(1'b0, 5'd2, 5'd16, 6'd5, 32'h0, 1'b1, "t4c");

    // Overlapping ascending copy
    for (int k = 0; k < 4; k++) mem[k] = 7 + k;
    run_cmd(1'b0, 5'd0, 5'd1, 6'd3, 32'h0, 1'b0, "t5");
    check("t5_sum21", checksum, 32'd21);
    check("t5_m3", mem[3], 32'd7);

    // Reset in the middle of a long fill after five writes
    for (int k = 0; k < 32; k++) ref_mem[k] = mem[k];
    for (int k = 0; k < 5; k++) ref_mem[10 + k] = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dst = 5'd10; len = 6'd32; pattern = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_cs", 32'(mem_cs), 0);
    check("t6_we", 32'(mem_we), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_mem", mem_diffs(), 0);
    run_cmd(1'b1, 5'd0, 5'd20, 6'd3, 32'h0BAD_F00D, 1'b0, "t6n");

    // Random commands, including clamped lengths and overlaps
    for (int t = 0; t < 24; t++) begin
      rs = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      rp = $urandom;
      run_cmd(1'($urandom_range(0, 1)), rs, rd, 6'($urandom_range(0, 40)), rp,
              1'($urandom_range(0, 1)), $sformatf("r%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
